// File: rtl/c4_pkg.sv
// c4_pkg: shared Connect-4 board constants and types used by the drop/commit logic.
package c4_pkg;

    localparam int unsigned COLS = 7;
    localparam int unsigned ROWS = 6;

    typedef logic [2:0] col_t;
    typedef logic [2:0] row_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_e;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        PLACE
    } drop_state_e;

endpackage

// File: rtl/drop_tick.sv
// drop_tick: per-row dwell timer for the falling-piece animation; expire pulses on the
// last cycle of each FALL_TICKS-long dwell and the counter reloads itself while running.
module drop_tick #(
    parameter int unsigned FALL_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(FALL_TICKS - 1);

    logic [CW-1:0] count_q;

    assign expire = run && (count_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= RELOAD;
        end else if (run) begin
            count_q <= (count_q == '0) ? RELOAD : count_q - 1'b1;
        end
    end

endmodule

// File: rtl/column_drop.sv
// column_drop: owns the Connect-4 board; validates a confirmed column and commits the piece.
// Define COLUMN_DROP_ANIM_EN to animate the piece falling row by row before the commit.
module column_drop
    import c4_pkg::*;
#(
    parameter int unsigned COLS       = c4_pkg::COLS,
    parameter int unsigned ROWS       = c4_pkg::ROWS,
    parameter int unsigned FALL_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      drop_valid,
    input  logic [2:0]                drop_col,
    output logic                      drop_ready,
    output logic                      drop_ack,
    output logic                      drop_nack,
    output logic                      turn,
    output logic [ROWS-1:0][COLS-1:0] p1_board,
    output logic [ROWS-1:0][COLS-1:0] p2_board,
    output logic [2:0]                placed_row,
    output logic [2:0]                placed_col,
    output logic                      fall_active,
    output logic [2:0]                fall_row,
    output logic                      board_full
);

    if (FALL_TICKS == 0 || ROWS > 7 || COLS > 8) begin : g_bad_params
        $error("column_drop: FALL_TICKS must be >= 1, ROWS <= 7, COLS <= 8");
    end

    drop_state_e               state_q, state_d;
    player_e                   turn_q;
    row_t                      height_q [COLS];
    logic [ROWS-1:0][COLS-1:0] p1_q, p2_q;
    logic                      nack_q, full_q, full_next;
    row_t                      placed_row_q, cur_h, commit_row;
    col_t                      placed_col_q, commit_col;
    logic                      bad_drop, accept, do_commit;

    // Height lookup by comparison so an out-of-range column never indexes the array.
    always_comb begin
        cur_h = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (drop_col == col_t'(c)) cur_h = height_q[c];
        end
    end

    assign bad_drop = (32'(drop_col) >= COLS) || (32'(cur_h) >= ROWS) || full_q;
    assign accept   = (state_q == IDLE) && drop_valid && !bad_drop && !clear;

`ifdef COLUMN_DROP_ANIM_EN
    col_t col_q;
    row_t row_q, fall_row_q;
    logic expire;

    drop_tick #(
        .FALL_TICKS(FALL_TICKS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .run   ((state_q == FALL) && !clear),
        .expire(expire)
    );

    assign do_commit  = (state_q == FALL) && expire && (fall_row_q == row_q) && !clear;
    assign commit_col = col_q;
    assign commit_row = row_q;
    assign fall_row   = fall_row_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            fall_row_q <= '0;
        end else if (clear) begin
            fall_row_q <= '0;
        end else if (accept) begin
            col_q      <= drop_col;
            row_q      <= cur_h;
            fall_row_q <= row_t'(ROWS - 1);
        end else if ((state_q == FALL) && expire && !do_commit) begin
            fall_row_q <= fall_row_q - 1'b1;
        end
    end
`else
    assign do_commit  = accept;
    assign commit_col = drop_col;
    assign commit_row = cur_h;
    assign fall_row   = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef COLUMN_DROP_ANIM_EN
                    if (accept) state_d = FALL;
`else
                    if (accept) state_d = PLACE;
`endif
                end
                FALL:    if (do_commit) state_d = PLACE;
                PLACE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        drop_ready  = (state_q == IDLE) && !full_q;
        drop_ack    = (state_q == PLACE);
`ifdef COLUMN_DROP_ANIM_EN
        fall_active = (state_q == FALL);
`else
        fall_active = 1'b0;
`endif
    end

    // Fullness after the pending commit, so board_full is valid in the ack cycle.
    always_comb begin
        int unsigned hc;
        full_next = 1'b1;
        for (int unsigned c = 0; c < COLS; c++) begin
            hc = 32'(height_q[c]);
            if (col_t'(c) == commit_col) hc = hc + 1;
            if (hc < ROWS) full_next = 1'b0;
        end
    end

    // The piece is written on the edge entering PLACE, so PLACE is the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_q         <= '0;
            p2_q         <= '0;
            turn_q       <= P1;
            nack_q       <= 1'b0;
            full_q       <= 1'b0;
            placed_row_q <= '0;
            placed_col_q <= '0;
            for (int unsigned c = 0; c < COLS; c++) height_q[c] <= '0;
        end else if (clear) begin
            p1_q   <= '0;
            p2_q   <= '0;
            turn_q <= P1;
            nack_q <= 1'b0;
            full_q <= 1'b0;
            for (int unsigned c = 0; c < COLS; c++) height_q[c] <= '0;
        end else begin
            nack_q <= drop_valid && ((state_q != IDLE) || bad_drop);
            if (do_commit) begin
                if (turn_q == P1) p1_q[commit_row][commit_col] <= 1'b1;
                else              p2_q[commit_row][commit_col] <= 1'b1;
                for (int unsigned c = 0; c < COLS; c++) begin
                    if ((col_t'(c) == commit_col) && (32'(height_q[c]) < ROWS))
                        height_q[c] <= height_q[c] + row_t'(1);
                end
                placed_row_q <= commit_row;
                placed_col_q <= commit_col;
                turn_q       <= (turn_q == P1) ? P2 : P1;
                full_q       <= full_next;
            end
        end
    end

    assign drop_nack  = nack_q;
    assign turn       = turn_q;
    assign p1_board   = p1_q;
    assign p2_board   = p2_q;
    assign placed_row = placed_row_q;
    assign placed_col = placed_col_q;
    assign board_full = full_q;

endmodule

// File: tb/tb_column_drop.sv
// tb_column_drop: directed self-checking bench for column_drop, with a small board model;
// expected latencies follow COLUMN_DROP_ANIM_EN when it is defined for the build.
module tb_column_drop;

    localparam int unsigned FT = 2;

    logic             clk, reset, clear, drop_valid;
    logic [2:0]       drop_col;
    logic             drop_ready, drop_ack, drop_nack, turn;
    logic [5:0][6:0]  p1_board, p2_board;
    logic [2:0]       placed_row, placed_col, fall_row;
    logic             fall_active, board_full;

    int checks = 0;
    int errors = 0;

    logic [5:0][6:0]  exp_p1, exp_p2;
    int unsigned      exp_h [7];
    logic             exp_turn, exp_full;
    int unsigned      exp_row, exp_col;

    column_drop #(
        .COLS      (7),
        .ROWS      (6),
        .FALL_TICKS(FT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .drop_valid (drop_valid),
        .drop_col   (drop_col),
        .drop_ready (drop_ready),
        .drop_ack   (drop_ack),
        .drop_nack  (drop_nack),
        .turn       (turn),
        .p1_board   (p1_board),
        .p2_board   (p2_board),
        .placed_row (placed_row),
        .placed_col (placed_col),
        .fall_active(fall_active),
        .fall_row   (fall_row),
        .board_full (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_p1   = '0;
        exp_p2   = '0;
        exp_turn = 1'b0;
        exp_full = 1'b0;
        for (int c = 0; c < 7; c++) exp_h[c] = 0;
    endtask

    task automatic check_board(input string tag);
        check({tag, "_p1"},   64'(p1_board),   64'(exp_p1));
        check({tag, "_p2"},   64'(p2_board),   64'(exp_p2));
        check({tag, "_turn"}, 64'(turn),       64'(exp_turn));
        check({tag, "_full"}, 64'(board_full), 64'(exp_full));
    endtask

    // One drop into col; poke > 0 pulses an extra drop_valid in that cycle of the fall.
    task automatic drop_expect(input int unsigned col, input int unsigned poke);
        int unsigned h, exp_lat, limit, ack_k, nack_k;
        bit exp_ok;
        h      = (col < 7) ? exp_h[col] : 0;
        exp_ok = (col < 7) && (h < 6) && !exp_full;
`ifdef COLUMN_DROP_ANIM_EN
        exp_lat = exp_ok ? 1 + (6 - h) * FT : 1;
`else
        exp_lat = 1;
`endif
        limit = exp_lat + 3;
        drop_col   = 3'(col);
        drop_valid = 1'b1;
        step();
        drop_valid = 1'b0;
        check("ready_after_sample", 64'(drop_ready), 64'(!exp_ok && !exp_full));
        ack_k  = 0;
        nack_k = 0;
        for (int unsigned k = 1; k <= limit; k++) begin
            if (drop_nack && nack_k == 0) nack_k = k;
            if (drop_ack) begin
                ack_k = k;
                break;
            end
            if (!exp_ok && nack_k != 0) break;
`ifdef COLUMN_DROP_ANIM_EN
            if (exp_ok) begin
                check("fall_active", 64'(fall_active), 64'(1));
                check("fall_row", 64'(fall_row), 64'(5 - (k - 1) / FT));
            end
            if (k == poke) begin
                drop_col   = 3'd0;
                drop_valid = 1'b1;
            end
`endif
            step();
            drop_valid = 1'b0;
        end
        check("ack_seen", 64'(ack_k != 0), 64'(exp_ok));
        if (exp_ok) check("ack_latency", 64'(ack_k), 64'(exp_lat));
        check("nack_cycle", 64'(nack_k), 64'(exp_ok ? (poke != 0 ? poke + 1 : 0) : 1));
        if (exp_ok) begin
            if (exp_turn) exp_p2[h][col] = 1'b1;
            else          exp_p1[h][col] = 1'b1;
            exp_h[col]++;
            exp_turn = !exp_turn;
            exp_row  = h;
            exp_col  = col;
            exp_full = 1'b1;
            for (int c = 0; c < 7; c++) if (exp_h[c] < 6) exp_full = 1'b0;
        end
        check_board("drop");
        check("placed_row", 64'(placed_row), 64'(exp_row));
        check("placed_col", 64'(placed_col), 64'(exp_col));
        check("ready_in_resp", 64'(drop_ready), 64'(!exp_ok && !exp_full));
        check("fall_idle_resp", 64'(fall_active), 64'(0));
        step();
        check("ready_next", 64'(drop_ready), 64'(!exp_full));
        check("ack_single", 64'(drop_ack), 64'(0));
    endtask

    initial begin
        int unsigned pulses;
        reset      = 1'b0;
        clear      = 1'b0;
        drop_valid = 1'b0;
        drop_col   = '0;
        model_clear();
        exp_row = 0;
        exp_col = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        step();

        check_board("reset");
        check("reset_ready", 64'(drop_ready), 64'(1));
        check("reset_ack",   64'(drop_ack),   64'(0));
        check("reset_nack",  64'(drop_nack),  64'(0));
        check("reset_fall",  64'(fall_active), 64'(0));
        check("reset_fall_row", 64'(fall_row), 64'(0));
        check("reset_placed", 64'({placed_row, placed_col}), 64'(0));

        drop_expect(3, 0);
        check("p1_cell_0_3", 64'(p1_board[0][3]), 64'(1));
        drop_expect(7, 0);
        for (int i = 0; i < 7; i++) drop_expect(0, 0);
`ifdef COLUMN_DROP_ANIM_EN
        drop_expect(5, 4);
`else
        drop_expect(5, 0);
`endif
        for (int unsigned c = 0; c < 7; c++) begin
            while (exp_h[c] < 6) drop_expect(c, 0);
        end
        check("full_flag", 64'(board_full), 64'(1));
        check("full_ready", 64'(drop_ready), 64'(0));
        drop_expect(2, 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        check_board("clear");
        check("clear_ready", 64'(drop_ready), 64'(1));
        check("clear_pulses", 64'({drop_ack, drop_nack}), 64'(0));

        drop_expect(4, 0);
        clear      = 1'b1;
        drop_valid = 1'b1;
        drop_col   = 3'd1;
        step();
        clear      = 1'b0;
        drop_valid = 1'b0;
        model_clear();
        check_board("clear_drop");
        check("clear_drop_pulses", 64'({drop_ack, drop_nack}), 64'(0));
        check("clear_drop_ready", 64'(drop_ready), 64'(1));
        step();
        check("clear_drop_pulses2", 64'({drop_ack, drop_nack}), 64'(0));
        check("clear_drop_p1", 64'(p1_board), 64'(0));

        drop_col   = 3'd2;
        drop_valid = 1'b1;
        step();
        drop_valid = 1'b0;
`ifdef COLUMN_DROP_ANIM_EN
        step();
        step();
        check("midfall_active", 64'(fall_active), 64'(1));
`endif
        #2 reset = 1'b0;
        #1;
        model_clear();
        exp_row = 0;
        exp_col = 0;
        check_board("async_reset");
        check("async_reset_pulses", 64'({drop_ack, drop_nack}), 64'(0));
        check("async_reset_fall", 64'(fall_active), 64'(0));
        check("async_reset_ready", 64'(drop_ready), 64'(1));
        check("async_reset_placed", 64'({placed_row, placed_col}), 64'(0));
        #3 reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (drop_ack || drop_nack) pulses++;
        end
        check("post_reset_pulses", 64'(pulses), 64'(0));
        check_board("post_reset");

        drop_expect(6, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_drop.md
# column_drop

Board-side responder to the column-select front end: accepts a confirmed column (`drop_valid` + `drop_col`), validates it, optionally animates the piece falling row by row, then commits it to the lowest empty cell and passes the turn. It owns the authoritative Connect-4 board state (per-player occupancy planes, column heights, whose turn) consumed by the display and win-check logic.

## Interface
- `COLS`, 7, number of columns (col index 0..COLS-1)
- `ROWS`, 6, number of rows (row 0 = bottom)
- `FALL_TICKS`, 2, cycles the falling piece dwells on each row (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous new-game request
- `drop_valid`  in  1  one-cycle pulse: confirmed column present
- `drop_col`  in  3  column to drop into
- `drop_ready`  out  1  high in IDLE when board not full
- `drop_ack`  out  1  one-cycle pulse: piece committed
- `drop_nack`  out  1  one-cycle pulse: drop refused
- `turn`  out  1  player to move (0 = P1, 1 = P2)
- `p1_board`, `p2_board`  out  ROWS×COLS  occupancy planes, [row][col]
- `placed_row`, `placed_col`  out  3 each  cell of last committed piece
- `fall_active`  out  1  animation in progress
- `fall_row`  out  3  current row of falling piece (valid when `fall_active`)
- `board_full`  out  1  all ROWS·COLS cells occupied

## Operation
- Reset (async, `reset`=0): boards 0, heights 0, `turn`=0, state IDLE, all pulses 0, `placed_*`=0, `fall_*`=0, `board_full`=0.
- States: IDLE, FALL, PLACE.
- IDLE, `drop_valid`=1 sampled:
  - refuse if `drop_col`≥COLS, height[col]==ROWS, or `board_full` → `drop_nack` pulse, board/turn unchanged, stay IDLE.
  - else latch col, target row h = height[col]; go FALL (macro on) or PLACE (macro off).
- FALL: `fall_row` starts at ROWS-1, dwells FALL_TICKS cycles per row, decrements; after dwelling on row h → PLACE.
- PLACE (one cycle): set cell (h,col) in plane of `turn`, height[col]++, `placed_*` updated, toggle `turn`, `drop_ack` pulse, recompute `board_full`; → IDLE.
- `drop_valid` while not IDLE: `drop_nack` pulse, no other effect.
- `clear`: highest priority below reset; boards/heights/turn to reset values, aborts FALL/PLACE, no ack/nack that cycle; simultaneous `drop_valid` discarded.
- Heights held as 3-bit counters saturating at ROWS; never written past ROWS.

## Timing
- Latency counted from sampling edge to `drop_ack` cycle.
- Macro off: ack latency 1; board planes and `turn` reflect the new piece in the ack cycle.
- Macro on: ack latency 1 + (ROWS−h)·FALL_TICKS; e.g. h=0, ROWS=6, FALL_TICKS=2 → 13.
- `drop_nack` latency 1 in all cases.
- `drop_ready` falls the cycle after an accepted sample, rises in the cycle after the ack cycle.
- Back-to-back drops: next drop may be sampled the cycle after the ack cycle.

## Configuration
- `COLUMN_DROP_ANIM_EN` defined: FALL state and tick counter present; `fall_active`/`fall_row` animate as above.
- Undefined: IDLE→PLACE directly; `fall_active` tied 0, `fall_row` tied 0; ack latency 1.

## Structure
- Package `c4_pkg`: `COLS`, `ROWS` constants, `col_t` (3-bit), `row_t` (3-bit), `player_e` enum (P1, P2), `drop_state_e` enum (IDLE, FALL, PLACE).
- Sub-module `drop_tick`: FALL_TICKS down-counter with `start`/`expire`; instantiated only under `COLUMN_DROP_ANIM_EN`.

## Test plan
- Reset, macro off, drop col 3 → ack at latency 1, p1_board[0][3]=1, placed=(0,3), turn=1.
- Six drops into col 0 then a seventh → sixth ack leaves height 6 with alternating planes; seventh → nack, boards unchanged, turn unchanged.
- `drop_col`=7 → nack at latency 1, no state change.
- Macro on, FALL_TICKS=2, empty col 5 → fall_row 5,5,4,4,…,0,0, ack at latency 13; drop_valid mid-fall → nack, fall unaffected.
- Fill all 42 cells → board_full=1, drop_ready=0, any further drop → nack; `clear` → board empty, turn=0, drop_ready=1.
- `clear` and `drop_valid` same cycle, and `reset` asserted mid-FALL → no ack/nack, board empty, state IDLE.
